timer_ctrl: RTL
===============

TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32, giving the counter, compare and data width.
REQ-002 SHALL have parameter PRESC_W, default 8, giving the prescaler field width.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port wr_en, input, 1, register write strobe.
REQ-006 SHALL have port rd_en, input, 1, register read strobe.
REQ-007 SHALL have port addr, input, 2, register select: 0 CTRL, 1 COMPARE, 2 COUNT, 3 STATUS.
REQ-008 SHALL have port wr_data, input, CNT_W, write data.
REQ-009 SHALL have port rd_data, output, CNT_W, registered read data.
REQ-010 SHALL have port rd_valid, output, 1, one-cycle pulse qualifying rd_data.
REQ-011 SHALL have port irq_timer, output, 1, level interrupt.
REQ-012 SHALL have port timer_cnt, output, CNT_W, live counter value.

Function
REQ-013 CTRL fields SHALL be: [1:0] mode (00 stop, 01 free-run, 10 clear-on-compare, 11 one-shot); [2] ovf_ie; [3] cmp_ie; [4+PRESC_W-1:4] presc.
REQ-014 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-015 A CTRL write with mode!=00 SHALL enter RUN from any state, clear the counter and clear the prescaler.
REQ-016 A CTRL write with mode==00 SHALL enter IDLE; the counter holds its value.
REQ-017 A tick SHALL occur once every presc+1 clocks while in RUN; no ticks occur in IDLE or DONE.
REQ-018 Free-run: each tick SHALL increment the counter modulo 2^CNT_W; the FFFFFFFF->0 wrap sets STATUS[0] (ovf).
REQ-019 Clear-on-compare: a tick with count==COMPARE SHALL load 0 and set STATUS[1] (cmp); with COMPARE=0 the count stays 0 and cmp sets every tick.
REQ-020 One-shot: a tick with count==COMPARE SHALL set cmp, hold the count and enter DONE.
REQ-021 One-shot with count past COMPARE SHALL wrap, set ovf and continue until a match.
REQ-022 A COUNT write SHALL load wr_data into the counter and clear the prescaler; this write wins over a same-cycle tick.
REQ-023 A COMPARE write SHALL take effect for ticks from the next clock.
REQ-024 A STATUS write SHALL clear each bit written as 1 (W1C).
REQ-025 A hardware set of a STATUS bit SHALL win over a same-cycle W1C clear of that bit.
REQ-026 irq_timer SHALL be registered: (ovf&ovf_ie)|(cmp&cmp_ie), one clock after the flag or enable changes.
REQ-027 A read SHALL return rd_data with rd_valid one clock after rd_en; otherwise rd_valid=0 and rd_data holds.
REQ-028 STATUS reads SHALL return [0] ovf, [1] cmp and [3:2] state (00 IDLE, 01 RUN, 10 DONE); all other bits read 0.
REQ-029 A simultaneous rd_en and wr_en to the same address SHALL return the pre-write value.

Reset
REQ-030 Reset SHALL set the state to IDLE and clear CTRL, COMPARE, counter, prescaler, STATUS, rd_data, rd_valid and irq_timer to 0.
REQ-031 Reset SHALL take priority over all other activity in the same cycle, including mid-count.

Configuration
REQ-032 With TIMER_CTRL_PRESCALER_EN defined, the presc field SHALL be implemented as in REQ-017.
REQ-033 Without TIMER_CTRL_PRESCALER_EN, the block SHALL tick every RUN clock and the CTRL presc field SHALL read 0 and ignore writes.

Verification
REQ-034 Bench SHALL cover free-run wrap: write COUNT=FFFFFFFD, then CTRL=0x5 -> CTRL write clears count to 0; repeat COUNT=FFFFFFFD after the start -> wrap to 0 after 3 ticks, ovf=1, irq_timer=1 on the next clock.
REQ-035 Bench SHALL cover clear-on-compare: COMPARE=4, CTRL=0xA -> count 0,1,2,3,4,0; cmp sets and irq asserts every 5 clocks once cleared.
REQ-036 Bench SHALL cover one-shot with prescaler: COMPARE=3, presc=2, mode 11 -> match after 12 clocks, state DONE, count holds 3, STATUS reads 0x2|(2<<2).
REQ-037 Bench SHALL cover the W1C race: W1C of cmp in the same cycle as a compare match -> cmp remains 1; a W1C one clock later -> cmp=0 and irq_timer deasserts the following clock.
REQ-038 Bench SHALL cover reset mid-run: assert reset at count=7 in RUN -> next clock all outputs 0, state IDLE, no tick until a new CTRL write.
REQ-039 Bench SHALL cover read timing: rd_en at addr 2 -> rd_valid=1 the next clock with the sampled count.

Source files
------------

// File: rtl/timer_ctrl.sv
// timer_ctrl: register-mapped timer with free-run, clear-on-compare and
// one-shot modes, W1C status flags and a registered level interrupt.
// Optional feature macro: TIMER_CTRL_PRESCALER_EN enables the CTRL presc
// field. Without it the timer ticks every RUN clock and presc reads 0.
module timer_ctrl #(
    parameter int CNT_W   = 32,
    parameter int PRESC_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [1:0]       addr,
    input  logic [CNT_W-1:0] wr_data,
    output logic [CNT_W-1:0] rd_data,
    output logic             rd_valid,
    output logic             irq_timer,
    output logic [CNT_W-1:0] timer_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [1:0] A_CTRL    = 2'd0;
    localparam logic [1:0] A_COMPARE = 2'd1;
    localparam logic [1:0] A_COUNT   = 2'd2;
    localparam logic [1:0] A_STATUS  = 2'd3;

    localparam logic [1:0] M_FREE = 2'b01;
    localparam logic [1:0] M_CLR  = 2'b10;
    localparam logic [1:0] M_ONE  = 2'b11;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t             state_q, state_d;
    logic [1:0]         mode_q;
    logic               ovf_ie_q, cmp_ie_q;
    logic [CNT_W-1:0]   compare_q, count_q, cnt_d;
    logic               ovf_q, cmp_q;
    logic               ovf_set, cmp_set, to_done;
    logic               tick, eff_tick;
    logic [PRESC_W-1:0] presc_rd;
    logic [CNT_W-1:0]   rd_mux;

    logic wr_ctrl, wr_compare, wr_count, wr_status, start, stop;

    assign wr_ctrl    = wr_en && (addr == A_CTRL);
    assign wr_compare = wr_en && (addr == A_COMPARE);
    assign wr_count   = wr_en && (addr == A_COUNT);
    assign wr_status  = wr_en && (addr == A_STATUS);
    assign start      = wr_ctrl && (wr_data[1:0] != 2'b00);
    assign stop       = wr_ctrl && (wr_data[1:0] == 2'b00);

`ifdef TIMER_CTRL_PRESCALER_EN
    localparam logic [PRESC_W-1:0] PRESC_ONE = PRESC_W'(1);

    logic [PRESC_W-1:0] presc_q, presc_cnt_q;

    assign tick     = (state_q == RUN) && (presc_cnt_q == presc_q);
    assign presc_rd = presc_q;

    // Prescaler divider: restarts on a tick, a timer start or a COUNT load
    always_ff @(posedge clk) begin
        if (reset)
            presc_cnt_q <= '0;
        else if (start || wr_count || tick)
            presc_cnt_q <= '0;
        else if (state_q == RUN)
            presc_cnt_q <= presc_cnt_q + PRESC_ONE;
    end

    // Stored prescaler field
    always_ff @(posedge clk) begin
        if (reset)
            presc_q <= '0;
        else if (wr_ctrl)
            presc_q <= wr_data[4 +: PRESC_W];
    end
`else
    assign tick     = (state_q == RUN);
    assign presc_rd = '0;
`endif

    // Any CTRL or COUNT write overrides the counting action of this clock
    assign eff_tick = tick && !wr_ctrl && !wr_count;

    // Next counter value, flag sets and next FSM state
    always_comb begin
        cnt_d   = count_q;
        ovf_set = 1'b0;
        cmp_set = 1'b0;
        to_done = 1'b0;
        state_d = state_q;
        if (eff_tick) begin
            case (mode_q)
                M_FREE: begin
                    cnt_d   = count_q + CNT_ONE;
                    ovf_set = (count_q == '1);
                end
                M_CLR: begin
                    if (count_q == compare_q) begin
                        cnt_d   = '0;
                        cmp_set = 1'b1;
                    end else begin
                        cnt_d   = count_q + CNT_ONE;
                        ovf_set = (count_q == '1);
                    end
                end
                M_ONE: begin
                    if (count_q == compare_q) begin
                        cmp_set = 1'b1;
                        to_done = 1'b1;
                    end else begin
                        cnt_d   = count_q + CNT_ONE;
                        ovf_set = (count_q == '1);
                    end
                end
                default: ;
            endcase
        end
        if (start)
            state_d = RUN;
        else if (stop)
            state_d = IDLE;
        else if (to_done)
            state_d = DONE;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // CTRL mode/enable fields and COMPARE register
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q    <= 2'b00;
            ovf_ie_q  <= 1'b0;
            cmp_ie_q  <= 1'b0;
            compare_q <= '0;
        end else begin
            if (wr_ctrl) begin
                mode_q   <= wr_data[1:0];
                ovf_ie_q <= wr_data[2];
                cmp_ie_q <= wr_data[3];
            end
            if (wr_compare)
                compare_q <= wr_data;
        end
    end

    // Counter: start clears, COUNT write loads, otherwise follow tick logic
    always_ff @(posedge clk) begin
        if (reset)
            count_q <= '0;
        else if (start)
            count_q <= '0;
        else if (wr_count)
            count_q <= wr_data;
        else
            count_q <= cnt_d;
    end

    // Status flags: hardware set beats a same-clock W1C
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
            cmp_q <= 1'b0;
        end else begin
            ovf_q <= ovf_set | (ovf_q & ~(wr_status & wr_data[0]));
            cmp_q <= cmp_set | (cmp_q & ~(wr_status & wr_data[1]));
        end
    end

    // Registered interrupt from current flags and enables
    always_ff @(posedge clk) begin
        if (reset)
            irq_timer <= 1'b0;
        else
            irq_timer <= (ovf_q & ovf_ie_q) | (cmp_q & cmp_ie_q);
    end

    // Read mux of pre-write register values
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en)
                rd_data <= rd_mux;
        end
    end

    // Register read decode
    always_comb begin
        rd_mux = '0;
        case (addr)
            A_CTRL: begin
                rd_mux[1:0]         = mode_q;
                rd_mux[2]           = ovf_ie_q;
                rd_mux[3]           = cmp_ie_q;
                rd_mux[4 +: PRESC_W] = presc_rd;
            end
            A_COMPARE: rd_mux = compare_q;
            A_COUNT:   rd_mux = count_q;
            default: begin
                rd_mux[0]   = ovf_q;
                rd_mux[1]   = cmp_q;
                rd_mux[3:2] = state_q;
            end
        endcase
    end

    assign timer_cnt = count_q;

endmodule
